// File: rtl/conv11_ctrl.sv
// Sequencer for the 1x1 conv datapath: loops output channels, streams pixels, writes results.
// Optional CONV11_PAUSE_EN adds a pause input that stalls pixel reads during RUN.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | param RAM read for current channel
// RUN   | one pixel read per cycle (unless paused)
// DRAIN | 2 cycles, no reads, in-flight pixels finish with stable params
// DONE  | done pulse, channel index returns to 0
module conv11_ctrl #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int OUT_CH     = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CH_WIDTH   = 4,
  parameter int DATA_WIDTH = 8
) (
`ifdef CONV11_PAUSE_EN
  input  logic                  pause,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  w_rd_en,
  output logic [CH_WIDTH-1:0]   w_addr,
  output logic                  in_rd_en,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  conv11_en,
  input  logic                  calc_valid,
  input  logic [DATA_WIDTH-1:0] calc_result,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int N = IMG_W * IMG_H;
  localparam logic [ADDR_WIDTH-1:0] N_W     = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] LAST_P  = ADDR_WIDTH'(N - 1);
  localparam logic [CH_WIDTH-1:0]   LAST_CH = CH_WIDTH'(OUT_CH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state, next_state;
  logic [CH_WIDTH-1:0]   ch;
  logic [ADDR_WIDTH-1:0] p;
  logic [ADDR_WIDTH-1:0] base;
  logic                  drain_cnt;
  logic [ADDR_WIDTH-1:0] addr_d1, addr_d2;
  logic                  stall;

`ifdef CONV11_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    w_rd_en    = 1'b0;
    in_rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        w_rd_en    = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!stall) begin
          in_rd_en = 1'b1;
          if (p == LAST_P) next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 1'b0) next_state = (ch == LAST_CH) ? DONE : LOAD;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Channel base advances by N per channel so out_addr = ch*N + p needs no multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch        <= '0;
      p         <= '0;
      base      <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (in_rd_en) p <= (p == LAST_P) ? '0 : p + ADDR_WIDTH'(1);
      if (state == RUN && next_state == DRAIN)
        drain_cnt <= 1'b1;
      else if (state == DRAIN && drain_cnt != 1'b0)
        drain_cnt <= drain_cnt - 1'b1;
      if (state == DRAIN && drain_cnt == 1'b0 && ch != LAST_CH) begin
        ch   <= ch + CH_WIDTH'(1);
        base <= base + N_W;
      end
      if (state == DONE) begin
        ch   <= '0;
        base <= '0;
      end
    end
  end

  // Address pipe follows the read -> enable -> valid chain so it stays aligned under pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv11_en <= 1'b0;
      addr_d1   <= '0;
      addr_d2   <= '0;
    end else begin
      conv11_en <= in_rd_en;
      if (in_rd_en)  addr_d1 <= base + p;
      if (conv11_en) addr_d2 <= addr_d1;
    end
  end

  assign w_addr    = ch;
  assign in_addr   = p;
  assign out_addr  = addr_d2;
  assign out_data  = calc_result;
  assign out_wr_en = calc_valid & busy;

endmodule
